// File: rtl/snoop_pkg.sv
// Shared definitions for the snooping bus controller: bus op encodings,
// controller state encoding and default block field widths.
package snoop_pkg;

  localparam logic [1:0] BUS_RD  = 2'b00;
  localparam logic [1:0] BUS_RDX = 2'b01;
  localparam logic [1:0] BUS_WB  = 2'b10;

  localparam int DEF_TAG_W  = 2;
  localparam int DEF_DATA_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SNOOP,
    ST_MEM,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans from last+1 upward (wrapping) and
// returns the first active requester as a one-hot grant plus its index.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  int   pos;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Shared-bus controller: round-robin arbitration, one-cycle snoop broadcast,
// single memory access (read or write-back of flushed/evicted data), done pulse.
module snoop_bus_arbiter
  import snoop_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      Clock,
  input  logic                      Resetn,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [2*NUM_REQ-1:0]      req_op,
  input  logic [TAG_W*NUM_REQ-1:0]  req_tag,
  input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      shared,
  output logic                      bus_valid,
  output logic [1:0]                bus_op,
  output logic [TAG_W-1:0]          bus_tag,
  output logic [NUM_REQ-1:0]        bus_src,
  input  logic [NUM_REQ-1:0]        snoop_hit,
  input  logic [NUM_REQ-1:0]        snoop_flush,
  input  logic [DATA_W*NUM_REQ-1:0] snoop_data,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [TAG_W-1:0]          mem_tag,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_ack
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [1:0]        op_arr    [NUM_REQ];
  logic [TAG_W-1:0]  tag_arr   [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];
  logic [DATA_W-1:0] sdata_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign op_arr[gi]    = req_op[2*gi +: 2];
    assign tag_arr[gi]   = req_tag[TAG_W*gi +: TAG_W];
    assign wdata_arr[gi] = req_wdata[DATA_W*gi +: DATA_W];
    assign sdata_arr[gi] = snoop_data[DATA_W*gi +: DATA_W];
  end

  state_t              state_reg, state_next;
  logic [IDX_W-1:0]    last_reg, idx_reg;
  logic [NUM_REQ-1:0]  gnt_reg;
  logic [1:0]          op_reg;
  logic [TAG_W-1:0]    tag_reg;
  logic [DATA_W-1:0]   wdata_reg, rdata_reg, mem_wdata_reg;
  logic                shared_reg, we_reg;

  logic [NUM_REQ-1:0]  arb_grant;
  logic [IDX_W-1:0]    arb_idx;

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req   (req),
    .last  (last_reg),
    .grant (arb_grant),
    .idx   (arb_idx)
  );

  // The owner's own snoop replies never count as another cache's copy.
  logic [NUM_REQ-1:0] masked_hit, masked_flush;
  logic [IDX_W-1:0]   flush_idx;
  logic               flush_any;

  assign masked_hit   = snoop_hit & ~gnt_reg;
  assign masked_flush = snoop_flush & ~gnt_reg;

  always_comb begin
    flush_any = |masked_flush;
    flush_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked_flush[i]) flush_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (|req) state_next = ST_SNOOP;
      ST_SNOOP: state_next = ST_MEM;
      ST_MEM:   if (mem_ack) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      last_reg      <= IDX_W'(NUM_REQ - 1);
      idx_reg       <= '0;
      gnt_reg       <= '0;
      op_reg        <= BUS_RD;
      tag_reg       <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      mem_wdata_reg <= '0;
      shared_reg    <= 1'b0;
      we_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: if (|req) begin
          gnt_reg   <= arb_grant;
          idx_reg   <= arb_idx;
          op_reg    <= (op_arr[arb_idx] == 2'b11) ? BUS_RD : op_arr[arb_idx];
          tag_reg   <= tag_arr[arb_idx];
          wdata_reg <= wdata_arr[arb_idx];
        end
        ST_SNOOP: begin
          shared_reg <= |(masked_hit | masked_flush);
          if (op_reg == BUS_WB) begin
            we_reg        <= 1'b1;
            mem_wdata_reg <= wdata_reg;
            rdata_reg     <= wdata_reg;
          end else if (flush_any) begin
            we_reg        <= 1'b1;
            mem_wdata_reg <= sdata_arr[flush_idx];
            rdata_reg     <= sdata_arr[flush_idx];
          end else begin
            we_reg        <= 1'b0;
            mem_wdata_reg <= '0;
          end
        end
        ST_MEM: if (mem_ack && !we_reg) rdata_reg <= mem_rdata;
        ST_DONE: begin
          last_reg <= idx_reg;
          gnt_reg  <= '0;
        end
        default: ;
      endcase
    end
  end

  logic in_snoop, in_mem, in_done;
  assign in_snoop = (state_reg == ST_SNOOP);
  assign in_mem   = (state_reg == ST_MEM);
  assign in_done  = (state_reg == ST_DONE);

  assign gnt       = gnt_reg;
  assign done      = in_done ? gnt_reg : '0;
  assign rdata     = in_done ? rdata_reg : '0;
  assign shared    = in_done & shared_reg;
  assign bus_valid = in_snoop;
  assign bus_op    = in_snoop ? op_reg : 2'b00;
  assign bus_tag   = in_snoop ? tag_reg : '0;
  assign bus_src   = in_snoop ? gnt_reg : '0;
  assign mem_req   = in_mem;
  assign mem_we    = in_mem & we_reg;
  assign mem_tag   = in_mem ? tag_reg : '0;
  assign mem_wdata = in_mem ? mem_wdata_reg : '0;

endmodule
